apb_fll_cfg_master: RTL
=======================

APB_FLL_CFG_MASTER -- requirements
Module: apb_fll_cfg_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, SHALL set the FLL configuration word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the APB and FLL data width.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the number of flops in the ack synchronizer (minimum 2).
REQ-004 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of cycles before a transfer aborts (minimum 1).
REQ-005 The interface SHALL be one clock with asynchronous, active-low reset.
REQ-006 Ports SHALL be as follows.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write.
- paddr_i  in  32  APB byte address.
- pwdata_i  in  DATA_WIDTH  APB write data.
- prdata_o  out  DATA_WIDTH  APB read data.
- pready_o  out  1  APB ready.
- pslverr_o  out  1  APB error.
- fll_req_o  out  1  FLL cfg request, active high.
- fll_ack_i  in  1  FLL cfg grant, active high, asynchronous to clk_i.
- fll_addr_o  out  ADDR_WIDTH  FLL cfg word address.
- fll_wdata_o  out  DATA_WIDTH  FLL cfg write data.
- fll_rdata_i  in  DATA_WIDTH  FLL cfg read data, stable while ack is high.
- fll_web_o  out  1  FLL cfg write enable, active low.

Function
REQ-010 fll_ack_i SHALL pass through a SYNC_STAGES flop synchronizer; ack_s denotes its output.
REQ-011 The FSM SHALL have four states: IDLE, REQ, ACK_LOW, DONE.
REQ-012 IDLE -> REQ SHALL occur on psel_i & penable_i; in that same cycle the block SHALL latch fll_addr_o = paddr_i[ADDR_WIDTH+1:2], fll_wdata_o = pwdata_i, and fll_web_o = ~pwrite_i.
REQ-013 fll_req_o SHALL be 1 exactly while in REQ; addr, wdata and web SHALL stay constant from REQ entry until return to IDLE.
REQ-014 In REQ, ack_s = 1 SHALL cause a transition to ACK_LOW; on a read (web = 1) it SHALL also capture fll_rdata_i into the read-data register.
REQ-015 In ACK_LOW, ack_s = 0 SHALL cause a transition to DONE with err = 0; this enforces four-phase handshake completion before the next request.
REQ-016 DONE SHALL assert pready_o = 1 for exactly one cycle, with pslverr_o = err, then return to IDLE.
REQ-017 pready_o SHALL be 0 in every state except DONE; pslverr_o SHALL be 0 whenever pready_o = 0.
REQ-018 prdata_o SHALL present the read-data register in DONE for reads; it SHALL be 0 for writes and whenever pready_o = 0.
REQ-019 Timeout counter behaviour:
- cleared on entry to REQ;
- increments each cycle in REQ and ACK_LOW;
- when it reaches TIMEOUT_CYCLES, the FSM SHALL go to DONE with err = 1 and fll_req_o deasserted;
- on a read that times out, the read-data register SHALL be 0.
REQ-020 If a timeout occurs in the same cycle as the awaited ack_s transition, the ack transition SHALL take priority.
REQ-021 APB setup phase (psel_i & ~penable_i) SHALL NOT start a transfer; APB inputs outside IDLE SHALL be ignored.
REQ-022 paddr_i bits other than [ADDR_WIDTH+1:2] SHALL be ignored.
REQ-023 After a timeout, a late ack SHALL be tolerated: a new transfer SHALL NOT issue fll_req_o while ack_s = 1 (IDLE waits for ack_s = 0 before entering REQ).

Reset
REQ-030 On rst_ni = 0, asynchronously: FSM = IDLE; counter, read-data register and synchronizer = 0; fll_req_o = 0; fll_addr_o = 0; fll_wdata_o = 0; fll_web_o = 1; pready_o = 0; pslverr_o = 0; prdata_o = 0.
REQ-031 Reset asserted mid-transfer SHALL drop fll_req_o immediately; no pready_o pulse SHALL follow reset release.

Verification
REQ-040 Write: paddr = 0x8, pwdata = 0xDEADBEEF; FLL model acks 3 cycles after req and drops ack 1 cycle after req falls -> fll_addr_o = 2, fll_web_o = 0, one pready_o pulse, pslverr_o = 0.
REQ-041 Read: paddr = 0x4; FLL returns rdata = 0x12345678 with ack -> prdata_o = 0x12345678 during pready_o, fll_web_o = 1.
REQ-042 Timeout: TIMEOUT_CYCLES = 8, ack held 0 -> fll_req_o drops after 8 cycles in REQ, pready_o = 1, pslverr_o = 1, prdata_o = 0.
REQ-043 Late ack: after a timeout, ack rises and then a new APB access arrives -> fll_req_o stays 0 until ack_s = 0, then the transfer completes normally.
REQ-044 Reset mid-REQ: rst_ni pulled low while fll_req_o = 1 -> all outputs at reset values the same cycle, and no pready_o after release.
REQ-045 Back-to-back: two writes with minimum APB gap -> the second fll_req_o rises only after ack_s of the first has fallen; data ordering is preserved.

Source files
------------

// File: rtl/apb_fll_cfg_master.sv
// Bridges one APB access into a four-phase req/ack FLL config handshake with a timeout abort.
// Latency: ack sync plus handshake, bounded by TIMEOUT_CYCLES; APB is stalled (pready_o=0) until DONE.
module apb_fll_cfg_master #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [31:0]           paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic                  fll_req_o,
    input  logic                  fll_ack_i,
    output logic [ADDR_WIDTH-1:0] fll_addr_o,
    output logic [DATA_WIDTH-1:0] fll_wdata_o,
    input  logic [DATA_WIDTH-1:0] fll_rdata_i,
    output logic                  fll_web_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  ack_sync;
    logic                    ack_s;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    timeout;
    logic                    apb_access;
    logic                    unused_paddr;

    // Only the word-select bits of the byte address reach the FLL.
    assign unused_paddr = ^{paddr_i[31:ADDR_WIDTH+2], paddr_i[1:0]};

    assign ack_s      = ack_sync[SYNC_STAGES-1];
    assign timeout    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign apb_access = psel_i & penable_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], fll_ack_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            rdata_q     <= '0;
            fll_req_o   <= 1'b0;
            fll_addr_o  <= '0;
            fll_wdata_o <= '0;
            fll_web_o   <= 1'b1;
            pready_o    <= 1'b0;
            pslverr_o   <= 1'b0;
            prdata_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A late ack from an aborted transfer must clear before a new request goes out.
                    if (apb_access && !ack_s) begin
                        state       <= REQ;
                        fll_req_o   <= 1'b1;
                        cnt         <= '0;
                        fll_addr_o  <= paddr_i[ADDR_WIDTH+1:2];
                        fll_wdata_o <= pwdata_i;
                        fll_web_o   <= ~pwrite_i;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        state     <= ACK_LOW;
                        fll_req_o <= 1'b0;
                        cnt       <= cnt + CNT_W'(1);
                        if (fll_web_o) begin
                            rdata_q <= fll_rdata_i;
                        end
                    end else if (timeout) begin
                        state     <= DONE;
                        fll_req_o <= 1'b0;
                        rdata_q   <= '0;
                        pready_o  <= 1'b1;
                        pslverr_o <= 1'b1;
                        prdata_o  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK_LOW: begin
                    // The ack edge wins over a timeout landing in the same cycle.
                    if (!ack_s) begin
                        state     <= DONE;
                        pready_o  <= 1'b1;
                        pslverr_o <= 1'b0;
                        prdata_o  <= fll_web_o ? rdata_q : '0;
                    end else if (timeout) begin
                        state     <= DONE;
                        rdata_q   <= '0;
                        pready_o  <= 1'b1;
                        pslverr_o <= 1'b1;
                        prdata_o  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    pready_o  <= 1'b0;
                    pslverr_o <= 1'b0;
                    prdata_o  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
